// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing and lock qualification with retry/fault handling.
// Build option: PLL_FAULT_AUTORETRY_EN (FAULT re-arms after a timeout).
module pll_lock_supervisor #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_FILTER     = 8,
  parameter int unsigned LOCK_TIMEOUT    = 1000000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       extClock,
  input  logic       ext_rst_n,
  input  logic       pll_locked,
  output logic       pll_areset,
  output logic       lock_ok,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [1:0] state_dbg
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [FW-1:0]    FILT_DONE = FW'(LOCK_FILTER);
  localparam logic [FW-1:0]    FILT_ONE  = FW'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    LOCKED    = 2'd2,
    FAULT     = 2'd3
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [FW-1:0]    filt_q;
  logic [3:0]       retry_q;
  logic [7:0]       loss_q;
  logic             areset_q;
  logic             lock_ok_q;
  logic             fault_q;
  logic             lk_s;

  assign lk_s = sync_q[1];

  // pll_locked comes from another clock domain
  always_ff @(posedge extClock or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge extClock or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      filt_q    <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      areset_q  <= 1'b1;
      lock_ok_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          areset_q  <= 1'b1;
          lock_ok_q <= 1'b0;
          filt_q    <= '0;
          if (cnt_q == HOLD_LAST) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            areset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          areset_q <= 1'b0;
          cnt_q    <= cnt_q + CNT_ONE;
          filt_q   <= lk_s ? filt_q + FILT_ONE : '0;
          // a qualified lock beats a timeout landing on the same edge
          if (filt_q == FILT_DONE) begin
            state_q   <= LOCKED;
            lock_ok_q <= 1'b1;
            retry_q   <= '0;
            cnt_q     <= '0;
            filt_q    <= '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_q    <= '0;
            filt_q   <= '0;
            areset_q <= 1'b1;
            if (retry_q == RETRY_MAX) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= RESET_PLL;
              retry_q <= retry_q + 4'd1;
            end
          end
        end

        LOCKED: begin
          areset_q  <= 1'b0;
          lock_ok_q <= 1'b1;
          if (!lk_s) begin
            state_q   <= RESET_PLL;
            lock_ok_q <= 1'b0;
            areset_q  <= 1'b1;
            cnt_q     <= '0;
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 8'd1;
            end
          end
        end

        FAULT: begin
          areset_q  <= 1'b1;
          lock_ok_q <= 1'b0;
          fault_q   <= 1'b1;
`ifdef PLL_FAULT_AUTORETRY_EN
          // fault_q stays set; only ext_rst_n clears it
          if (cnt_q == TMO_LAST) begin
            state_q <= RESET_PLL;
            retry_q <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`endif
        end
      endcase
    end
  end

  assign pll_areset = areset_q;
  assign lock_ok    = lock_ok_q;
  assign fault      = fault_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;
  assign state_dbg  = state_q;

endmodule
